// File: rtl/ifm_buf_pkg.sv
// Shared constants, lane geometry and control-state encoding for the ifm_buf staging buffer.
// No logic and no latency; the package only holds types and widths.
package ifm_buf_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 128;
    localparam int NUM_W  = 4;

    localparam int LANE_W = 16;
    localparam int LANES  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

// File: rtl/ifm_buf_ram.sv
// Simple dual-port row store: one write port and one registered read port.
// Latency: read data appears the cycle after rd_en is sampled; writes land at the clock edge.
// Backpressure: none; the caller guarantees reads and writes never target the same entry together.
module ifm_buf_ram #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int WORD_W = 132
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_dat
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage array carries no reset so it can map onto a RAM macro.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ifm_buf.sv
// Batch staging buffer for unrolled IFM rows; fills from img2col, drains in address order.
// Latency: one cycle from accepted rd_en to rd_valid/rd_data; buf_empty rises with the rd_last row.
// Backpressure: writes during READY are dropped (sticky wr_err); rd_en outside READY is ignored.
// Build option IFM_BUF_ZERO_PAD_EN zeroes lanes at or above rd_num_valid on read.
module ifm_buf #(
    parameter int DEPTH  = ifm_buf_pkg::DEPTH,
    parameter int ADDR_W = ifm_buf_pkg::ADDR_W,
    parameter int DATA_W = ifm_buf_pkg::DATA_W,
    parameter int NUM_W  = ifm_buf_pkg::NUM_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              ifm_wr_en,
    input  logic [ADDR_W-1:0] ifm_wr_addr,
    input  logic [DATA_W-1:0] pixels_in,
    input  logic [NUM_W-1:0]  valid_num,
    input  logic              i2c_ready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [NUM_W-1:0]  rd_num_valid,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              buf_empty,
    output logic              wr_err
);

    import ifm_buf_pkg::*;

    localparam int WORD_W = DATA_W + NUM_W;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rp;
    logic [ADDR_W-1:0] rp_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;

    logic              wr_ok;
    logic              wr_drop;
    logic              pop;
    logic              pop_last;
    logic [ADDR_W:0]   wr_len;
    logic [NUM_W-1:0]  num_clamped;
    logic [WORD_W-1:0] ram_wr_dat;
    logic [WORD_W-1:0] ram_rd_dat;
    logic [DATA_W-1:0] ram_row;

    assign wr_ok    = ifm_wr_en && (state != READY);
    assign wr_drop  = ifm_wr_en && (state == READY);
    assign pop      = rd_en && (state == READY);
    assign wr_len   = {1'b0, ifm_wr_addr} + (ADDR_W+1)'(1);
    assign pop_last = pop && ({1'b0, rp} == (cnt - (ADDR_W+1)'(1)));

    assign num_clamped = (valid_num > NUM_W'(LANES)) ? NUM_W'(LANES) : valid_num;
    assign ram_wr_dat  = {num_clamped, pixels_in};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            rp    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            rp    <= rp_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Batch length is the highest written address + 1, restarted by the first write after EMPTY.
    always_comb begin
        state_nxt = state;
        rp_nxt    = rp;
        cnt_nxt   = cnt;
        buf_empty = (state == EMPTY);
        case (state)
            EMPTY: begin
                if (wr_ok) begin
                    cnt_nxt   = wr_len;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (wr_ok && (wr_len > cnt)) begin
                    cnt_nxt = wr_len;
                end
                if (i2c_ready) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (pop_last) begin
                    state_nxt = EMPTY;
                    rp_nxt    = '0;
                    cnt_nxt   = '0;
                end else if (pop) begin
                    rp_nxt = rp + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = EMPTY;
                rp_nxt    = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= pop;
            rd_last  <= pop_last;
            if (wr_drop) begin
                wr_err <= 1'b1;
            end
        end
    end

    ifm_buf_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clock   (clock),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (ifm_wr_addr),
        .wr_dat  (ram_wr_dat),
        .rd_en   (pop),
        .rd_addr (rp),
        .rd_dat  (ram_rd_dat)
    );

    assign ram_row      = ram_rd_dat[DATA_W-1:0];
    assign rd_num_valid = ram_rd_dat[DATA_W +: NUM_W];

`ifdef IFM_BUF_ZERO_PAD_EN
    always_comb begin
        rd_data = ram_row;
        for (int k = 0; k < LANES; k++) begin
            if (k >= int'(rd_num_valid)) begin
                rd_data[k*LANE_W +: LANE_W] = '0;
            end
        end
    end
`else
    assign rd_data = ram_row;
`endif

endmodule

// File: tb/tb_ifm_buf.sv
// Scoreboard bench for ifm_buf: stimulus pushes expected rows from a batch-level model,
// an independent negedge monitor pops and compares whenever rd_valid is seen.
module tb_ifm_buf;

    logic         clock;
    logic         rst_n;
    logic         ifm_wr_en;
    logic [4:0]   ifm_wr_addr;
    logic [127:0] pixels_in;
    logic [3:0]   valid_num;
    logic         i2c_ready;
    logic         rd_en;
    logic [127:0] rd_data;
    logic [3:0]   rd_num_valid;
    logic         rd_valid;
    logic         rd_last;
    logic         buf_empty;
    logic         wr_err;

    ifm_buf dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .ifm_wr_en    (ifm_wr_en),
        .ifm_wr_addr  (ifm_wr_addr),
        .pixels_in    (pixels_in),
        .valid_num    (valid_num),
        .i2c_ready    (i2c_ready),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_num_valid (rd_num_valid),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .buf_empty    (buf_empty),
        .wr_err       (wr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] data;
        int           num;
        bit           last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Batch-level reference: 0 = empty, 1 = filling, 2 = ready to drain.
    logic [127:0] m_mem [32];
    int           m_num [32];
    int           m_state;
    int           m_cnt;
    int           m_rp;
    bit           m_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_row(input logic [127:0] d, input int n);
        logic [127:0] one;
        logic [127:0] mask;
        one = 128'd1;
`ifdef IFM_BUF_ZERO_PAD_EN
        mask = (n >= 8) ? ~128'd0 : ((one << (16 * n)) - one);
`else
        mask = ~128'd0;
`endif
        return d & mask;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clock) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_rd_valid: got rd_valid=1 data=%h expected no output", rd_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_num_valid", 128'(rd_num_valid), 128'(e.num));
                check("rd_last", 128'(rd_last), 128'(e.last));
                if (e.last) begin
                    check("buf_empty_on_last", 128'(buf_empty), 128'd1);
                end
            end
        end
    end

    // One clock of stimulus; the model advances from the state seen before the edge.
    task automatic cyc(input bit we, input int wa, input logic [127:0] wd, input int wn,
                       input bit i2c, input bit re);
        int   s0;
        exp_t e;
        ifm_wr_en   = we;
        ifm_wr_addr = 5'(wa);
        pixels_in   = wd;
        valid_num   = 4'(wn);
        i2c_ready   = i2c;
        rd_en       = re;
        s0 = m_state;
        if (re && s0 == 2) begin
            e.num  = m_num[m_rp];
            e.data = model_row(m_mem[m_rp], e.num);
            e.last = (m_rp == m_cnt - 1);
            exp_q.push_back(e);
            if (e.last) begin
                m_state = 0;
                m_rp    = 0;
            end else begin
                m_rp++;
            end
        end
        if (we) begin
            if (s0 == 2) begin
                m_err = 1'b1;
            end else begin
                m_mem[wa % 32] = wd;
                m_num[wa % 32] = (wn > 8) ? 8 : wn;
                if (s0 == 0) begin
                    m_cnt   = (wa % 32) + 1;
                    m_state = 1;
                end else if ((wa % 32) + 1 > m_cnt) begin
                    m_cnt = (wa % 32) + 1;
                end
            end
        end
        if (i2c && s0 == 1) m_state = 2;
        @(posedge clock);
        #1;
        check("buf_empty", 128'(buf_empty), 128'(m_state == 0));
        check("wr_err", 128'(wr_err), 128'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        check("rows_outstanding_at_reset", 128'(exp_q.size()), 128'd0);
        rst_n       = 1'b0;
        ifm_wr_en   = 1'b0;
        ifm_wr_addr = '0;
        pixels_in   = '0;
        valid_num   = '0;
        i2c_ready   = 1'b0;
        rd_en       = 1'b0;
        m_state = 0;
        m_cnt   = 0;
        m_rp    = 0;
        m_err   = 1'b0;
        exp_q.delete();
        @(posedge clock);
        #1;
        check("reset_buf_empty", 128'(buf_empty), 128'd1);
        check("reset_rd_valid", 128'(rd_valid), 128'd0);
        check("reset_rd_last", 128'(rd_last), 128'd0);
        check("reset_wr_err", 128'(wr_err), 128'd0);
        check("reset_rd_data", rd_data, 128'd0);
        check("reset_rd_num_valid", 128'(rd_num_valid), 128'd0);
        rst_n = 1'b1;
    endtask

    task automatic drain(input bit gaps, input bit bad_writes);
        int guard;
        guard = 0;
        while (m_state == 2 && guard < 300) begin
            cyc(bad_writes && ($urandom_range(0, 9) == 0), $urandom_range(0, 31), rnd128(),
                $urandom_range(0, 15), 0, gaps ? ($urandom_range(0, 3) != 0) : 1'b1);
            guard++;
        end
        check("drain_within_budget", 128'(m_state == 2), 128'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish within time budget");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_num[i] = 0;
        end
        do_reset();

        // Normal batch: addresses 0..8, data = address, full rows.
        for (int a = 0; a < 9; a++) cyc(1, a, 128'(a), 8, 0, 0);
        cyc(0, 0, '0, 0, 1, 0);
        drain(0, 0);
        idle(2);

        // Partial rows and an out-of-range count that must clamp to 8.
        cyc(1, 0, ~128'd0, 3, 0, 0);
        cyc(1, 1, ~128'd0, 12, 0, 0);
        cyc(1, 2, rnd128(), 0, 1, 0);
        drain(0, 0);
        idle(1);

        // Write during READY is dropped and flags wr_err; contents survive.
        cyc(1, 0, 128'hA5A5, 8, 0, 0);
        cyc(1, 1, 128'h5A5A, 8, 1, 0);
        cyc(1, 0, 128'hDEAD, 8, 0, 0);
        drain(1, 0);
        idle(2);
        do_reset();

        // i2c_ready while empty is ignored, and pops then yield nothing.
        cyc(0, 0, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 0, 1);
        cyc(0, 0, '0, 0, 0, 1);
        idle(2);

        // Reset mid-drain, then a fresh two-row batch restarts at address 0.
        for (int a = 0; a < 9; a++) cyc(1, a, rnd128(), $urandom_range(0, 8), 0, 0);
        cyc(0, 0, '0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, 0, 0, 1);
        do_reset();
        cyc(1, 0, rnd128(), 5, 0, 0);
        cyc(1, 1, rnd128(), 7, 0, 0);
        cyc(0, 0, '0, 0, 1, 0);
        drain(0, 0);
        idle(1);

        // Randomized batches with overwrites, idle gaps, stray pops and dropped writes.
        for (int b = 0; b < 14; b++) begin
            int n;
            n = $urandom_range(1, 32);
            for (int i = 0; i < n; i++) begin
                cyc(1, i, rnd128(), $urandom_range(0, 15), (i > 0) && (i == n - 1) && $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            if (m_state == 1 && $urandom_range(0, 1) == 1)
                cyc(1, $urandom_range(0, n - 1), rnd128(), $urandom_range(0, 15), 0, 0);
            if (m_state == 1) cyc(0, 0, '0, 0, 1, 0);
            drain(1, 1);
            idle($urandom_range(1, 3));
            if (b == 7) do_reset();
        end

        idle(3);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
